// File: rtl/soc_timer_multi.sv
// Multi-channel timer peripheral behind an Ibex-style data-bus slave port.
// Each channel has its own prescaler, compare value and periodic/one-shot mode.
module soc_timer_multi #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned PSC_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              gnt,
  output logic              rvalid,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [NUM_CH-1:0] irq_ch,
  output logic              irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam logic [DATA_W-1:0] INFO_VAL = {16'h0, 8'(CNT_WIDTH), 8'(NUM_CH)};

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_PSC  = 2'd1;
  localparam logic [1:0] REG_CMP  = 2'd2;
  localparam logic [1:0] REG_CNT  = 2'd3;

  function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_val,
                                                 input logic [DATA_W-1:0] new_val,
                                                 input logic [DATA_W-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // Address decode: addr[8] selects the global block, addr[7:4] the channel.
  logic [6:0]        word;
  logic              global_sel;
  logic [SEL_W-1:0]  ch_sel;
  logic [1:0]        reg_sel;
  logic              ch_hit;
  logic              status_hit;
  logic              info_hit;
  logic              bad;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] byte_mask;
  logic              unused_addr;

  assign word        = addr[8:2];
  assign global_sel  = word[6];
  assign ch_sel      = word[5:2];
  assign reg_sel     = word[1:0];
  assign ch_hit      = !global_sel && (32'(ch_sel) < NUM_CH);
  assign status_hit  = global_sel && (word[5:0] == 6'd0);
  assign info_hit    = global_sel && (word[5:0] == 6'd1);
  assign bad         = !(ch_hit || status_hit || (info_hit && !we));
  assign wr_ok       = req && we && !bad;
  assign rd_ok       = req && !we && !bad;
  assign byte_mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign gnt         = req && !rst;
  assign unused_addr = ^{addr[31:9], addr[1:0]};

  logic [NUM_CH-1:0]                en_v;
  logic [NUM_CH-1:0]                oneshot_v;
  logic [NUM_CH-1:0]                irq_en_v;
  logic [NUM_CH-1:0]                match_v;
  logic [NUM_CH-1:0][PSC_WIDTH-1:0] psc_v;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] cmp_v;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_v;
  logic [NUM_CH-1:0]                status_q;
  logic [NUM_CH-1:0]                status_d;
  logic [NUM_CH-1:0]                w1c;
  logic [DATA_W-1:0]                rdata_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                 en_q, en_d;
    logic                 oneshot_q, oneshot_d;
    logic                 irq_en_q, irq_en_d;
    logic [PSC_WIDTH-1:0] psc_q, psc_d;
    logic [PSC_WIDTH-1:0] div_q, div_d;
    logic [CNT_WIDTH-1:0] cmp_q, cmp_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sel;
    logic                 tick;
    logic                 match;

    assign sel   = wr_ok && ch_hit && (ch_sel == SEL_W'(c));
    assign tick  = en_q && (div_q == psc_q);
    assign match = tick && (cnt_q == cmp_q);

    // Counter update first; a bus write to the same register then overrides it.
    always_comb begin
      en_d      = en_q;
      oneshot_d = oneshot_q;
      irq_en_d  = irq_en_q;
      psc_d     = psc_q;
      div_d     = div_q;
      cmp_d     = cmp_q;
      cnt_d     = cnt_q;
      if (en_q) begin
        div_d = tick ? '0 : div_q + PSC_WIDTH'(1);
      end
      if (tick) begin
        cnt_d = match ? '0 : cnt_q + CNT_WIDTH'(1);
        if (match && oneshot_q) begin
          en_d = 1'b0;
        end
      end
      if (sel) begin
        case (reg_sel)
          REG_CTRL: begin
            if (be[0]) begin
              en_d      = wdata[0];
              oneshot_d = wdata[1];
              irq_en_d  = wdata[2];
              if (wdata[0] && !en_q) begin
                div_d = '0;
              end
            end
          end
          REG_PSC: psc_d = PSC_WIDTH'(merge_be(DATA_W'(psc_q), wdata, byte_mask));
          REG_CMP: cmp_d = CNT_WIDTH'(merge_be(DATA_W'(cmp_q), wdata, byte_mask));
          REG_CNT: cnt_d = CNT_WIDTH'(merge_be(DATA_W'(cnt_q), wdata, byte_mask));
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        en_q      <= 1'b0;
        oneshot_q <= 1'b0;
        irq_en_q  <= 1'b0;
        psc_q     <= '0;
        div_q     <= '0;
        cmp_q     <= '0;
        cnt_q     <= '0;
      end else begin
        en_q      <= en_d;
        oneshot_q <= oneshot_d;
        irq_en_q  <= irq_en_d;
        psc_q     <= psc_d;
        div_q     <= div_d;
        cmp_q     <= cmp_d;
        cnt_q     <= cnt_d;
      end
    end

    assign en_v[c]      = en_q;
    assign oneshot_v[c] = oneshot_q;
    assign irq_en_v[c]  = irq_en_q;
    assign match_v[c]   = match;
    assign psc_v[c]     = psc_q;
    assign cmp_v[c]     = cmp_q;
    assign cnt_v[c]     = cnt_q;
  end

  // A match sets its STATUS bit even when a W1C of that bit lands on the same edge.
  assign w1c      = (wr_ok && status_hit) ? NUM_CH'(wdata & byte_mask) : '0;
  assign status_d = (status_q & ~w1c) | match_v;

  always_comb begin
    rdata_d = '0;
    if (rd_ok) begin
      if (status_hit) begin
        rdata_d = DATA_W'(status_q);
      end else if (info_hit) begin
        rdata_d = INFO_VAL;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_sel == SEL_W'(c)) begin
            case (reg_sel)
              REG_CTRL: rdata_d = {29'h0, irq_en_v[c], oneshot_v[c], en_v[c]};
              REG_PSC:  rdata_d = DATA_W'(psc_v[c]);
              REG_CMP:  rdata_d = DATA_W'(cmp_v[c]);
              REG_CNT:  rdata_d = DATA_W'(cnt_v[c]);
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      irq_ch   <= '0;
      irq      <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      err      <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_ch   <= status_q & irq_en_v;
      irq      <= |(status_q & irq_en_v);
      rvalid   <= req;
      rdata    <= rdata_d;
      err      <= req && bad;
    end
  end

endmodule
